// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts one command byte out on device clock falls and checks the device ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int REQ_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    input  logic       PS2CLK_IN,
    input  logic       PS2DATA_IN,
    output logic       PS2CLK_OE,
    output logic       PS2DATA_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERROR
);

    localparam int M1   = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int MAXC = (M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, REQ, SEND, ACK, RELEASE, FINISH, FAIL
    } state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [3:0]  bit_cnt;
    logic [9:0]  shreg;
    logic        clk_meta, clk_sync, clk_prev;
    logic        data_meta, data_sync;
    logic        fe;
    logic        timeout;

    // Idle-high bus, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= PS2CLK_IN;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= PS2DATA_IN;
            data_sync <= data_meta;
        end
    end

    assign fe      = clk_prev & ~clk_sync;
    assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            PS2CLK_OE  <= 1'b0;
            PS2DATA_OE <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
        end else begin
            DONE  <= 1'b0;
            ERROR <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (TX_START) begin
                        shreg     <= {1'b1, ~^TX_DATA, TX_DATA};
                        cnt       <= '0;
                        PS2CLK_OE <= 1'b1;
                        BUSY      <= 1'b1;
                        state     <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                        cnt        <= '0;
                        PS2DATA_OE <= 1'b1;
                        state      <= REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                REQ: begin
                    // Data stays low here: that is the start bit.
                    if (cnt == CW'(REQ_CYCLES - 1)) begin
                        cnt       <= '0;
                        bit_cnt   <= '0;
                        PS2CLK_OE <= 1'b0;
                        state     <= SEND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (fe) begin
                        cnt        <= '0;
                        PS2DATA_OE <= ~shreg[0];
                        shreg      <= shreg >> 1;
                        bit_cnt    <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd9) state <= ACK;
                    end else if (timeout) begin
                        PS2CLK_OE  <= 1'b0;
                        PS2DATA_OE <= 1'b0;
                        ERROR      <= 1'b1;
                        state      <= FAIL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    if (fe) begin
                        cnt <= '0;
                        if (!data_sync) begin
                            state <= RELEASE;
                        end else begin
                            ERROR <= 1'b1;
                            state <= FAIL;
                        end
                    end else if (timeout) begin
                        ERROR <= 1'b1;
                        state <= FAIL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    if (clk_sync && data_sync) begin
                        DONE  <= 1'b1;
                        state <= FINISH;
                    end else if (fe) begin
                        cnt <= '0;
                    end else if (timeout) begin
                        ERROR <= 1'b1;
                        state <= FAIL;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FINISH, FAIL: begin
                    PS2CLK_OE  <= 1'b0;
                    PS2DATA_OE <= 1'b0;
                    BUSY       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host
// while a spec-level model predicts every output on every cycle.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int REQ = 10;
    localparam int TO  = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       clk_oe, data_oe, busy, done, error;
    logic       ps2clk, ps2data;

    int compared = 0;
    int mismatched = 0;
    int pcyc = 0;
    int last_fall = 0;
    int last_end = 0;
    int clk_rise = 0, clk_fall = 0, data_rise = 0;
    bit pclk_oe = 0, pdata_oe = 0, data_armed = 0;
    bit chk = 0;

    assign ps2clk  = dev_clk & ~clk_oe;
    assign ps2data = dev_data & ~data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES(REQ),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .TX_DATA(tx_data),
        .TX_START(tx_start),
        .PS2CLK_IN(ps2clk),
        .PS2DATA_IN(ps2data),
        .PS2CLK_OE(clk_oe),
        .PS2DATA_OE(data_oe),
        .BUSY(busy),
        .DONE(done),
        .ERROR(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, pcyc);
        end
    endtask

    // Spec-level model: timing measured from acceptance, device clock
    // falls seen through a two-cycle synchronizer delay.
    bit m_busy, m_clk_oe, m_data_oe, m_done, m_error, m_pulse;
    bit cp1 = 1, cp2 = 1, cp3 = 1, dp1 = 1, dp2 = 1;
    bit m_fe, m_cs, m_ds, m_par;
    int n = 0, t_acc = 0, fe_n = 0, quiet = 0, k = 0;
    logic [9:0] frame;

    task automatic model_fail();
        m_error   = 1;
        m_pulse   = 1;
        m_clk_oe  = 0;
        m_data_oe = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_clk_oe = 0; m_data_oe = 0;
            m_done = 0; m_error = 0; m_pulse = 0;
            cp1 = 1; cp2 = 1; cp3 = 1; dp1 = 1; dp2 = 1;
        end else begin
            n++;
            m_fe = !cp2 && cp3;
            m_cs = cp2;
            m_ds = dp2;
            cp3 = cp2; cp2 = cp1; cp1 = ps2clk;
            dp2 = dp1; dp1 = ps2data;
            m_done = 0;
            m_error = 0;
            if (m_pulse) begin
                m_pulse = 0;
                m_busy  = 0;
            end else if (!m_busy) begin
                if (tx_start) begin
                    m_busy   = 1;
                    m_clk_oe = 1;
                    t_acc    = n;
                    m_par    = ($countones(tx_data) % 2) == 0;
                    frame    = {1'b1, m_par, tx_data};
                end
            end else begin
                k = n - t_acc;
                if (k == INH) m_data_oe = 1;
                if (k == INH + REQ) begin
                    m_clk_oe = 0;
                    fe_n = 0;
                    quiet = 0;
                end else if (k > INH + REQ) begin
                    if (fe_n == 11) begin
                        if (m_cs && m_ds) begin
                            m_done  = 1;
                            m_pulse = 1;
                        end else if (m_fe) quiet = 0;
                        else if (quiet == TO - 1) model_fail();
                        else quiet++;
                    end else if (m_fe) begin
                        fe_n++;
                        quiet = 0;
                        if (fe_n <= 10) m_data_oe = ~frame[fe_n-1];
                        else if (m_ds) model_fail();
                    end else if (quiet == TO - 1) model_fail();
                    else quiet++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("busy", busy, m_busy);
            check("clk_oe", clk_oe, m_clk_oe);
            check("data_oe", data_oe, m_data_oe);
            check("done", done, m_done);
            check("error", error, m_error);
        end
    end

    always @(negedge clk) begin
        if (clk_oe && !pclk_oe) begin
            clk_rise = pcyc;
            data_armed = 1;
        end
        if (!clk_oe && pclk_oe) clk_fall = pcyc;
        if (data_oe && !pdata_oe && data_armed) begin
            data_rise = pcyc;
            data_armed = 0;
        end
        pclk_oe = clk_oe;
        pdata_oe = data_oe;
    end

    // Device: waits for request-to-send, then generates nclk clock pulses,
    // reading the data line at the end of each low phase.
    task automatic device(input int nclk, input int per, input bit ack,
                          output logic [9:0] seen, output bit ok);
        int w;
        seen = '0;
        ok = 1;
        w = 0;
        while (!(ps2clk === 1'b1 && ps2data === 1'b0) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            ok = 0;
            return;
        end
        for (int i = 1; i <= nclk; i++) begin
            if (i == 11 && ack) begin
                repeat (per / 4) @(negedge clk);
                dev_data = 0;
                repeat (per / 4) @(negedge clk);
            end else begin
                repeat (per / 2) @(negedge clk);
            end
            dev_clk = 0;
            last_fall = pcyc;
            repeat (per / 2) @(negedge clk);
            if (i <= 10) seen[i-1] = ps2data;
            dev_clk = 1;
        end
        if (ack) begin
            repeat (per / 4) @(negedge clk);
            dev_data = 1;
        end
    endtask

    task automatic wait_end(input bit poke, output bit gd, output bit ge, output int at);
        int w;
        w = 0;
        while (!(done || error) && w < 30000) begin
            @(negedge clk);
            w++;
        end
        check("end_seen", done | error, 1);
        gd = done;
        ge = error;
        at = pcyc;
        if (error) check("oe_released", {clk_oe, data_oe}, 0);
        if (poke) begin
            tx_data = 8'h55;
            tx_start = 1;
        end
        @(negedge clk);
        tx_start = 0;
        check("pulse_one_cycle", done | error, 0);
        check("busy_after_pulse", busy, 0);
        repeat (5) @(negedge clk);
        check("stay_idle", busy, 0);
    endtask

    task automatic send(input logic [7:0] d, input int per, input int nclk, input bit ack,
                        input bit poke, output logic [9:0] seen, output bit gd, output bit ge);
        bit ok;
        int at;
        @(negedge clk);
        tx_data = d;
        tx_start = 1;
        @(negedge clk);
        tx_start = 0;
        check("busy_on_accept", busy, 1);
        check("clk_oe_on_accept", clk_oe, 1);
        fork
            device(nclk, per, ack, seen, ok);
            wait_end(poke, gd, ge, at);
        join
        check("device_saw_rts", ok, 1);
        last_end = at;
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] seen;
        bit gd, ge, ok;

        repeat (3) @(negedge clk);
        chk = 1;
        check("rst_busy", busy, 0);
        check("rst_clk_oe", clk_oe, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        rst = 0;
        repeat (5) @(negedge clk);

        send(8'hED, 1000, 11, 1, 1, seen, gd, ge);
        check("ed_frame", seen, {1'b1, 1'b1, 8'hED});
        check("ed_done", gd, 1);
        check("ed_error", ge, 0);

        send(8'h01, 400, 11, 1, 0, seen, gd, ge);
        check("01_frame", seen, {1'b1, 1'b0, 8'h01});
        check("01_ok", {gd, ge}, 2'b10);
        send(8'h00, 400, 11, 1, 0, seen, gd, ge);
        check("00_frame", seen, {1'b1, 1'b1, 8'h00});
        check("00_ok", {gd, ge}, 2'b10);
        send(8'hFF, 400, 11, 1, 0, seen, gd, ge);
        check("ff_frame", seen, {1'b1, 1'b1, 8'hFF});
        check("ff_ok", {gd, ge}, 2'b10);

        fork
            send(8'hF4, 1000, 11, 1, 0, seen, gd, ge);
            begin
                repeat (3000) @(negedge clk);
                tx_data = 8'hAA;
                tx_start = 1;
                @(negedge clk);
                tx_start = 0;
            end
        join
        check("f4_frame", seen, {1'b1, 1'b0, 8'hF4});
        check("f4_ok", {gd, ge}, 2'b10);
        check("f4_clk_oe_len", clk_fall - clk_rise, 110);
        check("f4_data_oe_at", data_rise - clk_rise, 100);

        send(8'h3C, 1000, 11, 0, 0, seen, gd, ge);
        check("noack_error", ge, 1);
        check("noack_done", gd, 0);

        send(8'h96, 1000, 4, 0, 0, seen, gd, ge);
        check("timeout_error", ge, 1);
        check("timeout_done", gd, 0);
        check("timeout_latency", last_end - last_fall, 2003);

        @(negedge clk);
        tx_data = 8'h00;
        tx_start = 1;
        @(negedge clk);
        tx_start = 0;
        device(5, 400, 0, seen, ok);
        check("rst_test_rts", ok, 1);
        repeat (20) @(negedge clk);
        check("pre_rst_data_oe", data_oe, 1);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_clk_oe", clk_oe, 0);
        @(posedge clk);
        #2 rst = 1;
        #1;
        check("async_rst_data_oe", data_oe, 0);
        check("async_rst_clk_oe", clk_oe, 0);
        check("async_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);

        send(8'h5A, 400, 11, 1, 0, seen, gd, ge);
        check("5a_frame", seen, {1'b1, 1'b1, 8'h5A});
        check("5a_ok", {gd, ge}, 2'b10);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED "set LEDs" or 0xFF "reset") from the MCU to the keyboard over the same open-drain PS2CLK/PS2DATA pair that the keyboard driver receives on. It runs in the 100 MHz CLK domain of the wrapper. TX_DATA/TX_START are loaded from an output-port decode (IO_STRB with a dedicated port ID). BUSY lets the wrapper mask the receiver while a transmission is in flight.

## Interface
Parameters:
- INHIBIT_CYCLES, 12000: CLK cycles the host holds PS2CLK low before request-to-send (120 µs).
- REQ_CYCLES, 500: CLK cycles with both lines held low before PS2CLK is released (5 µs).
- TIMEOUT_CYCLES, 200000: maximum CLK cycles allowed between device falling edges, and before line release after ACK (2 ms).

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-high reset.
- TX_DATA  in  8  command byte; sampled only on an accepted TX_START.
- TX_START  in  1  single-cycle request; ignored while BUSY=1.
- PS2CLK_IN  in  1  PS2CLK pin level (asynchronous).
- PS2DATA_IN  in  1  PS2DATA pin level (asynchronous).
- PS2CLK_OE  out  1  1 = drive PS2CLK low; 0 = release (tristate, pulled up).
- PS2DATA_OE  out  1  1 = drive PS2DATA low; 0 = release.
- BUSY  out  1  high from acceptance until DONE or ERROR.
- DONE  out  1  one-cycle pulse: byte sent and ACK received.
- ERROR  out  1  one-cycle pulse: timeout or missing ACK.

## Operation
- Synchronization: PS2CLK_IN and PS2DATA_IN each pass through 2 flops. A falling edge ("fe") is sync2=0 with previous sync2=1. All protocol decisions use synchronized values only.
- Frame: start 0, D0..D7 LSB first, odd parity (~^TX_DATA), stop 1, then device ACK (0).
- FSM states:
  - IDLE: all OE=0. TX_START latches the shift register and parity, then goes to INHIBIT.
  - INHIBIT: CLK_OE=1 for INHIBIT_CYCLES, then REQ.
  - REQ: CLK_OE=1, DATA_OE=1 for REQ_CYCLES. Then CLK_OE=0 and go to SEND with bit index 0. DATA_OE stays 1, which is the start bit.
  - SEND: on each fe, present the next bit: DATA_OE = ~bit. fe #1..#8 → D0..D7, fe #9 → parity, fe #10 → stop (DATA_OE=0). After fe #10, go to ACK.
  - ACK: on the next fe, sample PS2DATA. 0 → RELEASE; 1 → FAIL.
  - RELEASE: wait until both synchronized lines are 1, then FINISH.
  - FINISH: DONE=1 for one cycle, then IDLE.
  - FAIL: all OE=0, ERROR=1 for one cycle, then IDLE.
- Timeout: a counter clears on entry to SEND and on every fe in SEND, ACK and RELEASE. If it reaches TIMEOUT_CYCLES in any of those states, go to FAIL.
- Lines are never both released early: DATA_OE changes only in REQ entry, on an fe, or on FAIL/IDLE.
- BUSY = (state != IDLE). It is 0 in the DONE/ERROR pulse cycle's successor.

## Timing
- Reset (asynchronous): state IDLE, PS2CLK_OE=0, PS2DATA_OE=0, BUSY=0, DONE=0, ERROR=0, counters 0, sync flops 1.
- Reset mid-frame releases both lines immediately (asynchronously).
- All outputs are registered.
- TX_START at edge N → BUSY=1 and PS2CLK_OE=1 after edge N+1.
- PS2CLK_OE falls exactly INHIBIT_CYCLES+REQ_CYCLES cycles after it rose.
- PS2DATA_OE rises exactly INHIBIT_CYCLES cycles after PS2CLK_OE rose.
- Pin fall → PS2DATA_OE update: 3 CLK cycles (2 sync + 1 register). This is well inside the device's ≥30 µs low phase.
- DONE/ERROR assert exactly one cycle; BUSY deasserts on the same edge the pulse deasserts.
- A TX_START coincident with the DONE/ERROR pulse is ignored. It is accepted only when BUSY=0 at the sampling edge.
- Device clock pulses arriving during INHIBIT/REQ are ignored, with no bit advance.

## Test plan
(Bench uses INHIBIT_CYCLES=100, REQ_CYCLES=10, TIMEOUT_CYCLES=2000, and a device model clocking at 1000-cycle periods.)
- Send 0xED → data line after each fe reads 1,0,1,1,0,1,1,1, parity 1, stop 1. Model ACKs; DONE pulses once; BUSY low the cycle after.
- Send 0x01 → parity 0. Send 0x00 and 0xFF → parity 1 in both. Each produces DONE with no ERROR.
- TX_START with 0xF4 → PS2CLK_OE high exactly 110 cycles. PS2DATA_OE rises at cycle 100. A second TX_START (0xAA) mid-frame is ignored; 0xF4 is transmitted.
- Model omits ACK (data stays 1 on fe #11) → ERROR pulse, both OE=0, no DONE.
- Model stops clocking after fe #4 → ERROR exactly 2000 cycles after fe #4; lines released; BUSY=0.
- RESET asserted during SEND bit 5 → both OE=0 and BUSY=0 without a CLK edge. A new TX_START after reset completes normally.
